// File: rtl/blackjack_turn_ctrl_if.sv
// Player buttons, card-source handshake and game result signals of blackjack_turn_ctrl.
// The controller uses the slave modport and the driving environment uses the master modport.
interface blackjack_turn_ctrl_if;
    logic       start;
    logic       player1_go;
    logic       player1_stop;
    logic       player2_go;
    logic       player2_stop;
    logic       card_req;
    logic       card_valid;
    logic [3:0] card_value;
    logic [5:0] player1_card;
    logic [5:0] player2_card;
    logic       player1_surrender;
    logic       player2_surrender;
    logic [1:0] active_player;
    logic       done;
    logic [1:0] winner;

    modport master (
        output start, player1_go, player1_stop, player2_go, player2_stop,
        output card_valid, card_value,
        input  card_req, player1_card, player2_card,
        input  player1_surrender, player2_surrender,
        input  active_player, done, winner
    );

    modport slave (
        input  start, player1_go, player1_stop, player2_go, player2_stop,
        input  card_valid, card_value,
        output card_req, player1_card, player2_card,
        output player1_surrender, player2_surrender,
        output active_player, done, winner
    );
endinterface

// File: rtl/blackjack_turn_ctrl.sv
// Two-player blackjack turn sequencer: deals the opening hand, runs each player's turn,
// pulls cards over a request/valid handshake and declares the winner.
module blackjack_turn_ctrl #(
    parameter int BUST_LIMIT = 21,
    parameter int TIMEOUT    = 15
) (
    input  logic                 i_clk,
    input  logic                 i_clr,
    blackjack_turn_ctrl_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [5:0]    LIMIT   = 6'(BUST_LIMIT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAL,
        S_P1_TURN,
        S_P1_DRAW,
        S_P2_TURN,
        S_P2_DRAW,
        S_RESOLVE,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [1:0]    r_dealIdx;
    logic [TW-1:0] r_timeout;
    logic [5:0]    r_p1Total;
    logic [5:0]    r_p2Total;
    logic          r_p1Bust;
    logic          r_p2Bust;
    logic [1:0]    r_winner;

    logic [5:0] w_cardPts;
    logic [5:0] w_p1Sum;
    logic [5:0] w_p2Sum;
    logic       w_cardReq;
    logic       w_accept;

    // Rank 0 counts as an ace (1) and ranks 12-15 are face cards worth 10.
    assign w_cardPts = (bus.card_value == 4'd0)  ? 6'd1  :
                       (bus.card_value >= 4'd12) ? 6'd10 :
                       {2'b00, bus.card_value};
    assign w_p1Sum   = r_p1Total + w_cardPts;
    assign w_p2Sum   = r_p2Total + w_cardPts;
    assign w_cardReq = (r_state == S_DEAL) || (r_state == S_P1_DRAW) || (r_state == S_P2_DRAW);
    assign w_accept  = w_cardReq && bus.card_valid;

    assign bus.card_req          = w_cardReq;
    assign bus.player1_card      = r_p1Total;
    assign bus.player2_card      = r_p2Total;
    assign bus.player1_surrender = r_p1Bust;
    assign bus.player2_surrender = r_p2Bust;
    assign bus.done              = (r_state == S_DONE);
    assign bus.winner            = r_winner;
    assign bus.active_player     = ((r_state == S_P1_TURN) || (r_state == S_P1_DRAW)) ? 2'b01 :
                                   ((r_state == S_P2_TURN) || (r_state == S_P2_DRAW)) ? 2'b10 :
                                   2'b00;

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state   <= S_IDLE;
            r_dealIdx <= '0;
            r_timeout <= '0;
            r_p1Total <= '0;
            r_p2Total <= '0;
            r_p1Bust  <= 1'b0;
            r_p2Bust  <= 1'b0;
            r_winner  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state   <= S_DEAL;
                        r_dealIdx <= '0;
                        r_timeout <= '0;
                        r_p1Total <= '0;
                        r_p2Total <= '0;
                        r_p1Bust  <= 1'b0;
                        r_p2Bust  <= 1'b0;
                        r_winner  <= 2'b00;
                    end
                end

                // Even deal slots go to player 1, odd slots to player 2.
                S_DEAL: begin
                    if (w_accept) begin
                        if (r_dealIdx[0]) r_p2Total <= w_p2Sum;
                        else              r_p1Total <= w_p1Sum;
                        r_dealIdx <= r_dealIdx + 2'd1;
                        if (r_dealIdx == 2'd3) begin
                            r_state   <= S_P1_TURN;
                            r_timeout <= '0;
                        end
                    end
                end

                // A dealt 21 or dealt bust ends the turn before any button is honoured.
                S_P1_TURN: begin
                    if (r_p1Total >= LIMIT) begin
                        if (r_p1Total > LIMIT) r_p1Bust <= 1'b1;
                        r_state   <= S_P2_TURN;
                        r_timeout <= '0;
                    end else if (bus.player1_stop) begin
                        r_state   <= S_P2_TURN;
                        r_timeout <= '0;
                    end else if (bus.player1_go) begin
                        r_state   <= S_P1_DRAW;
                        r_timeout <= '0;
                    end else if (r_timeout == TO_LAST) begin
                        r_state   <= S_P2_TURN;
                        r_timeout <= '0;
                    end else begin
                        r_timeout <= r_timeout + 1'b1;
                    end
                end

                S_P1_DRAW: begin
                    if (w_accept) begin
                        r_p1Total <= w_p1Sum;
                        r_timeout <= '0;
                        if (w_p1Sum > LIMIT) begin
                            r_p1Bust <= 1'b1;
                            r_state  <= S_P2_TURN;
                        end else if (w_p1Sum == LIMIT) begin
                            r_state  <= S_P2_TURN;
                        end else begin
                            r_state  <= S_P1_TURN;
                        end
                    end
                end

                S_P2_TURN: begin
                    if (r_p2Total >= LIMIT) begin
                        if (r_p2Total > LIMIT) r_p2Bust <= 1'b1;
                        r_state   <= S_RESOLVE;
                        r_timeout <= '0;
                    end else if (bus.player2_stop) begin
                        r_state   <= S_RESOLVE;
                        r_timeout <= '0;
                    end else if (bus.player2_go) begin
                        r_state   <= S_P2_DRAW;
                        r_timeout <= '0;
                    end else if (r_timeout == TO_LAST) begin
                        r_state   <= S_RESOLVE;
                        r_timeout <= '0;
                    end else begin
                        r_timeout <= r_timeout + 1'b1;
                    end
                end

                S_P2_DRAW: begin
                    if (w_accept) begin
                        r_p2Total <= w_p2Sum;
                        r_timeout <= '0;
                        if (w_p2Sum > LIMIT) begin
                            r_p2Bust <= 1'b1;
                            r_state  <= S_RESOLVE;
                        end else if (w_p2Sum == LIMIT) begin
                            r_state  <= S_RESOLVE;
                        end else begin
                            r_state  <= S_P2_TURN;
                        end
                    end
                end

                S_RESOLVE: begin
                    if (r_p1Bust && r_p2Bust)   r_winner <= 2'b00;
                    else if (r_p1Bust)          r_winner <= 2'b10;
                    else if (r_p2Bust)          r_winner <= 2'b01;
                    else if (r_p1Total > r_p2Total) r_winner <= 2'b01;
                    else if (r_p2Total > r_p1Total) r_winner <= 2'b10;
                    else                        r_winner <= 2'b11;
                    r_state <= S_DONE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blackjack_turn_ctrl.sv
// Directed bench for blackjack_turn_ctrl: expected values are queued as stimulus is driven
// and popped against the DUT outputs after each clock edge.
module tb_blackjack_turn_ctrl;
    logic clk;
    logic clr;

    blackjack_turn_ctrl_if bus ();

    blackjack_turn_ctrl dut (
        .i_clk (clk),
        .i_clr (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } expT;

    expT sb[$];
    int  compared   = 0;
    int  mismatched = 0;
    logic [5:0] m1;
    logic [5:0] m2;

    function automatic logic [5:0] pts(input logic [3:0] v);
        if (v == 4'd0)   return 6'd1;
        if (v >= 4'd12)  return 6'd10;
        return {2'b00, v};
    endfunction

    task automatic pushExp(input string tag, input logic [7:0] v);
        expT e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input logic [7:0] observed);
        expT e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL sb_empty observed=%0d required=an expected entry", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.val) else begin
                mismatched++;
                $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, observed, e.val);
            end
        end
    endtask

    task automatic applyStimulus(input logic st, input logic g1, input logic s1,
                                 input logic g2, input logic s2, input logic vld,
                                 input logic [3:0] val);
        bus.start        = st;
        bus.player1_go   = g1;
        bus.player1_stop = s1;
        bus.player2_go   = g2;
        bus.player2_stop = s2;
        bus.card_valid   = vld;
        bus.card_value   = val;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic startGame();
        m1 = '0;
        m2 = '0;
        pushExp("start_card_req", 8'd1);
        pushExp("start_winner_clr", 8'd0);
        pushExp("start_done_clr", 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        checkOutput(bus.card_req);
        checkOutput(bus.winner);
        checkOutput(bus.done);
    endtask

    task automatic dealHand(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        logic [3:0] cards [4];
        cards[0] = a;
        cards[1] = b;
        cards[2] = c;
        cards[3] = d;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) m1 = m1 + pts(cards[i]);
            else            m2 = m2 + pts(cards[i]);
            pushExp("deal_card_req", (i < 3) ? 8'd1 : 8'd0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cards[i]);
            checkOutput(bus.card_req);
        end
        pushExp("deal_p1_total", 8'(m1));
        pushExp("deal_p2_total", 8'(m2));
        pushExp("deal_active", 8'd1);
        checkOutput(bus.player1_card);
        checkOutput(bus.player2_card);
        checkOutput(bus.active_player);
    endtask

    task automatic waitDone(input int maxCycles);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < maxCycles) begin
            tick();
            n++;
        end
        pushExp("done_wait", 8'd1);
        checkOutput(bus.done);
    endtask

    task automatic checkResetOutputs();
        pushExp("rst_card_req", 8'd0);
        pushExp("rst_p1_total", 8'd0);
        pushExp("rst_p2_total", 8'd0);
        pushExp("rst_p1_surr", 8'd0);
        pushExp("rst_p2_surr", 8'd0);
        pushExp("rst_active", 8'd0);
        pushExp("rst_done", 8'd0);
        pushExp("rst_winner", 8'd0);
        checkOutput(bus.card_req);
        checkOutput(bus.player1_card);
        checkOutput(bus.player2_card);
        checkOutput(bus.player1_surrender);
        checkOutput(bus.player2_surrender);
        checkOutput(bus.active_player);
        checkOutput(bus.done);
        checkOutput(bus.winner);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr              = 1'b1;
        bus.start        = 1'b0;
        bus.player1_go   = 1'b0;
        bus.player1_stop = 1'b0;
        bus.player2_go   = 1'b0;
        bus.player2_stop = 1'b0;
        bus.card_valid   = 1'b0;
        bus.card_value   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs();
        clr = 1'b0;
        tick();

        // Deal and stand: 17 vs 17 tie, start ignored mid-game
        startGame();
        dealHand(4'd10, 4'd9, 4'd7, 4'd8);
        pushExp("start_ignored_active", 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        checkOutput(bus.active_player);
        pushExp("p1_stop_active", 8'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        checkOutput(bus.active_player);
        pushExp("p2_stop_active", 8'd0);
        pushExp("resolve_done", 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        checkOutput(bus.active_player);
        checkOutput(bus.done);
        pushExp("tie_done", 8'd1);
        pushExp("tie_winner", 8'd3);
        tick();
        checkOutput(bus.done);
        checkOutput(bus.winner);

        // Player 1 busts, player 2 stands
        startGame();
        dealHand(4'd10, 4'd5, 4'd6, 4'd5);
        pushExp("p1_draw_card_req", 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        checkOutput(bus.card_req);
        m1 = m1 + pts(4'd10);
        pushExp("p1_bust_total", 8'(m1));
        pushExp("p1_bust_flag", 8'd1);
        pushExp("p1_bust_active", 8'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10);
        checkOutput(bus.player1_card);
        checkOutput(bus.player1_surrender);
        checkOutput(bus.active_player);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        pushExp("p1_bust_winner", 8'd2);
        tick();
        checkOutput(bus.winner);

        // Both bust
        startGame();
        dealHand(4'd10, 4'd10, 4'd6, 4'd6);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        m1 = m1 + pts(4'd10);
        pushExp("both_p1_total", 8'(m1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10);
        checkOutput(bus.player1_card);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        m2 = m2 + pts(4'd10);
        pushExp("both_p2_total", 8'(m2));
        pushExp("both_p2_flag", 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10);
        checkOutput(bus.player2_card);
        checkOutput(bus.player2_surrender);
        waitDone(5);
        pushExp("both_winner", 8'd0);
        checkOutput(bus.winner);

        // Dealt 21 stands automatically even with go held
        startGame();
        dealHand(4'd11, 4'd2, 4'd10, 4'd3);
        pushExp("auto21_active", 8'd2);
        pushExp("auto21_card_req", 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        checkOutput(bus.active_player);
        checkOutput(bus.card_req);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        pushExp("auto21_winner", 8'd1);
        tick();
        checkOutput(bus.winner);

        // Rank mapping, handshake stall, go+stop priority, player 2 timeout
        startGame();
        dealHand(4'd0, 4'd12, 4'd11, 4'd15);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            pushExp("stall_card_req", 8'd1);
            pushExp("stall_p1_total", 8'(m1));
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9);
            checkOutput(bus.card_req);
            checkOutput(bus.player1_card);
        end
        m1 = m1 + pts(4'd3);
        pushExp("stall_p1_plus3", 8'(m1));
        pushExp("stall_req_drop", 8'd0);
        pushExp("stall_active", 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        checkOutput(bus.player1_card);
        checkOutput(bus.card_req);
        checkOutput(bus.active_player);
        pushExp("prio_active", 8'd2);
        pushExp("prio_card_req", 8'd0);
        pushExp("prio_p1_total", 8'(m1));
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4);
        checkOutput(bus.active_player);
        checkOutput(bus.card_req);
        checkOutput(bus.player1_card);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 1'(i % 2), 1'(i == 3), 1'b0, 1'b0, 1'b1, 4'd5);
        end
        pushExp("to_still_p2", 8'd2);
        pushExp("to_p1_unchanged", 8'(m1));
        checkOutput(bus.active_player);
        checkOutput(bus.player1_card);
        pushExp("to_resolve_active", 8'd0);
        tick();
        checkOutput(bus.active_player);
        pushExp("to_winner", 8'd2);
        tick();
        checkOutput(bus.winner);

        // Asynchronous clear mid-deal, then a fresh game
        startGame();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10);
        #2 clr = 1'b1;
        #1;
        pushExp("clr_card_req", 8'd0);
        pushExp("clr_p1_total", 8'd0);
        checkOutput(bus.card_req);
        checkOutput(bus.player1_card);
        #2 clr = 1'b0;
        pushExp("clr_idle_card_req", 8'd0);
        tick();
        checkOutput(bus.card_req);
        startGame();
        dealHand(4'd4, 4'd5, 4'd6, 4'd7);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        pushExp("fresh_winner", 8'd2);
        tick();
        checkOutput(bus.winner);

        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL sb_leftover observed=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
